// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the 7-segment display blocks: scan FSM state
// encoding, active-low segment patterns ({g,f,e,d,c,b,a}) and the
// anode-select helper.
// ---------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [3:0] AN_OFF   = 4'hF;

    // Active-low anode vector with only the selected digit driven low
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD to active-low 7-segment decoder, shared by the display
// blocks. 10 decodes to a dash, 11..15 blank the digit.
//   bcd : 4-bit digit value
//   seg : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_to_seg
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit value to segment pattern lookup
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_DASH;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
// Multiplexed 4-digit 7-segment scanner. Each rising edge of the (level)
// scan-rate input steps to the next digit, with BLANK_CYCLES clk cycles of
// all-anodes-off between digits to avoid ghosting. A whole frame of inputs
// is captured at the start of digit 0 so the four digits are coherent.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   clk_500Hz : scan-rate square wave (sampled, not a clock)
//   clk_2Hz   : blink-rate square wave (sampled, not a clock)
//   digits    : four BCD digits, digit 0 in [3:0] (rightmost)
//   blink_en  : per-digit blink enable
//   dp_en     : per-digit decimal-point enable
//   lz_en     : leading-zero suppression enable
//   an        : active-low anode enables (at most one low)
//   seg       : active-low segments {g,f,e,d,c,b,a}
//   dp        : active-low decimal point
// ---------------------------------------------------------------------------
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_500Hz,
    input  logic        clk_2Hz,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_en,
    input  logic [3:0]  dp_en,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

    logic        scan_s1_r, scan_s2_r, scan_prev_r;
    logic        blink_s1_r, blink_s2_r;
    logic        step_s;

    scan_state_t state_r;
    logic [1:0]  idx_r;
    logic [7:0]  cnt_r;

    logic [15:0] sh_digits_r;
    logic [3:0]  sh_blink_r;
    logic [3:0]  sh_dp_r;
    logic        sh_lz_r;

    logic [15:0] shifted_s;
    logic [3:0]  cur_digit_s;
    logic        upper_zero_s;
    logic        hidden_s;
    logic [6:0]  dec_seg_s;
    logic [3:0]  disp_an_s;
    logic [6:0]  disp_seg_s;
    logic        disp_dp_s;

    // Two-flop synchronizers for both rate inputs plus scan edge history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_s1_r   <= 1'b0;
            scan_s2_r   <= 1'b0;
            scan_prev_r <= 1'b0;
            blink_s1_r  <= 1'b0;
            blink_s2_r  <= 1'b0;
        end else begin
            scan_s1_r   <= clk_500Hz;
            scan_s2_r   <= scan_s1_r;
            scan_prev_r <= scan_s2_r;
            blink_s1_r  <= clk_2Hz;
            blink_s2_r  <= blink_s1_r;
        end
    end

    assign step_s = scan_s2_r & ~scan_prev_r;

    // Current digit value; the shifted word is also all-zero exactly when
    // this digit and every higher digit are zero
    assign shifted_s    = sh_digits_r >> {idx_r, 2'b00};
    assign cur_digit_s  = shifted_s[3:0];
    assign upper_zero_s = (shifted_s == 16'h0000);

    assign hidden_s = (sh_blink_r[idx_r] & ~blink_s2_r)
                    | (sh_lz_r & (idx_r != 2'd0) & upper_zero_s);

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit_s),
        .seg (dec_seg_s)
    );

    // Next display values from current FSM state and shadow frame
    always_comb begin
        disp_an_s  = AN_OFF;
        disp_seg_s = SEG_OFF;
        disp_dp_s  = 1'b1;
        if ((state_r == ST_SHOW) && !hidden_s) begin
            disp_an_s  = an_select(idx_r);
            disp_seg_s = dec_seg_s;
            disp_dp_s  = ~sh_dp_r[idx_r];
        end else begin
            disp_an_s  = AN_OFF;
            disp_seg_s = SEG_OFF;
            disp_dp_s  = 1'b1;
        end
    end

    // Scan FSM, frame shadow capture and registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_BLANK;
            idx_r       <= 2'd0;
            cnt_r       <= 8'd0;
            sh_digits_r <= 16'h0000;
            sh_blink_r  <= 4'h0;
            sh_dp_r     <= 4'h0;
            sh_lz_r     <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            an  <= disp_an_s;
            seg <= disp_seg_s;
            dp  <= disp_dp_s;
            case (state_r)
                ST_BLANK: begin
                    // Step pulses arriving here are intentionally ignored
                    if (cnt_r == BLANK_LAST) begin
                        state_r <= ST_SHOW;
                        cnt_r   <= 8'd0;
                        if (idx_r == 2'd0) begin
                            sh_digits_r <= digits;
                            sh_blink_r  <= blink_en;
                            sh_dp_r     <= dp_en;
                            sh_lz_r     <= lz_en;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_SHOW: begin
                    if (step_s) begin
                        idx_r   <= idx_r + 2'd1;
                        state_r <= ST_BLANK;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= 8'd0;
                    end
                end
                default: begin
                    state_r <= ST_BLANK;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

endmodule
